// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Multiplexed 7-segment display driver. Scans N_DIGITS digits, one slot of
// SCAN_DIV clocks each, with a GUARD-cycle all-off window at the start of every
// slot to suppress ghosting. Supports hex decode, leading-zero blanking,
// per-digit decimal points and per-digit blinking.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   digits_in  : packed 4-bit digit values, digit 0 in bits [3:0]
//   load       : one-cycle strobe capturing digits_in, dp_mask, blink_mask
//   blank_lz   : leading-zero blanking enable (live)
//   dp_mask    : decimal point enable per digit
//   blink_mask : blink enable per digit
//   seg        : segment drive, [0]=a .. [6]=g (registered)
//   dp         : decimal point drive (registered)
//   an         : one-hot anode enable (registered)
//   frame_tick : pulse on the last cycle of the final digit slot
module seg7_scan_driver #(
  parameter int N_DIGITS     = 5,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 64,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [N_DIGITS-1:0]   dp_mask,
  input  logic [N_DIGITS-1:0]   blink_mask,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_tick
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(N_DIGITS);
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] GUARD_END  = PW'(GUARD);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(N_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  // XOR mask applied to every output to reach the requested polarity
  localparam logic          INV        = (ACTIVE_LOW != 0);

  logic [PW-1:0]         presc;
  logic [SW-1:0]         slot;
  logic [BW-1:0]         blink_cnt;
  logic                  blink_ph;
  logic [4*N_DIGITS-1:0] sh_digits;
  logic [N_DIGITS-1:0]   sh_dp;
  logic [N_DIGITS-1:0]   sh_blink;

  logic [3:0]            cur_digit;
  logic                  cur_dp;
  logic                  cur_blink;
  logic                  cur_blank;
  logic [N_DIGITS-1:0]   an_sel;
  logic [N_DIGITS-1:0]   lz_vec;
  logic                  zero_run;
  logic                  slot_on;
  logic                  hide;
  logic [6:0]            seg_n;
  logic                  dp_n;
  logic [N_DIGITS-1:0]   an_n;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign frame_tick = (presc == PRESC_LAST) && (slot == SLOT_LAST);

  // Scan timing, blink phase and shadow content
  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      slot      <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      sh_digits <= '0;
      sh_dp     <= '0;
      sh_blink  <= '0;
    end else begin
      if (load) begin
        sh_digits <= digits_in;
        sh_dp     <= dp_mask;
        sh_blink  <= blink_mask;
      end
      if (presc == PRESC_LAST) begin
        presc <= '0;
        slot  <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      if (frame_tick) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // Leading-zero detection: lz_vec[i] is set when digit i and all digits above
  // it are zero. Digit 0 is excluded so a value of zero still shows "0".
  always_comb begin
    zero_run = 1'b1;
    lz_vec   = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run  = zero_run & (sh_digits[i*4 +: 4] == 4'h0);
      lz_vec[i] = zero_run;
    end
    lz_vec[0] = 1'b0;
  end

  // Current-slot selection; compare-based so slot codes above N_DIGITS-1
  // never index outside the vectors.
  always_comb begin
    cur_digit = 4'h0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_blank = 1'b0;
    an_sel    = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (slot == SW'(i)) begin
        cur_digit = sh_digits[i*4 +: 4];
        cur_dp    = sh_dp[i];
        cur_blink = sh_blink[i];
        cur_blank = blank_lz & lz_vec[i];
        an_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    slot_on = (presc >= GUARD_END);
    hide    = cur_blink & blink_ph;
    an_n    = slot_on ? an_sel : '0;
    seg_n   = (slot_on && !hide && !cur_blank) ? hex7(cur_digit) : 7'h00;
    // A blanked leading zero keeps its decimal point; blinking hides it
    dp_n    = slot_on & cur_dp & ~hide;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= {7{INV}};
      dp  <= INV;
      an  <= {N_DIGITS{INV}};
    end else begin
      seg <= seg_n ^ {7{INV}};
      dp  <= dp_n ^ INV;
      an  <= an_n ^ {N_DIGITS{INV}};
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int ND = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [4*ND-1:0] digits_in;
  logic          load;
  logic          blank_lz;
  logic [ND-1:0] dp_mask;
  logic [ND-1:0] blink_mask;
  logic [6:0]    seg;
  logic          dp;
  logic [ND-1:0] an;
  logic          frame_tick;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [6:0]    exp_seg [ND];
  logic          exp_dp  [ND];
  logic [ND-1:0] bm;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .N_DIGITS    (ND),
    .SCAN_DIV    (4),
    .GUARD       (1),
    .BLINK_FRAMES(2),
    .ACTIVE_LOW  (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digits_in (digits_in),
    .load      (load),
    .blank_lz  (blank_lz),
    .dp_mask   (dp_mask),
    .blink_mask(blink_mask),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_tick(frame_tick)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s at cyc %0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic wait_cyc(input int m, input int r);
    while (cyc % m != r) tick();
  endtask

  // One full 20-cycle frame, aligned so that output j reflects prescaler j%4
  // of slot j/4. Blink phase is 1 in frames 2,3,6,7,... since reset.
  task automatic run_frame();
    int f;
    int ph;
    int s;
    int p;
    wait_cyc(20, 0);
    f  = cyc / 20;
    ph = (f / 2) % 2;
    for (int j = 0; j < 20; j++) begin
      tick();
      p = j % 4;
      s = j / 4;
      if (p == 0) begin
        chk("guard_an", 32'(an), 32'h0);
        chk("guard_seg", 32'(seg), 32'h0);
        chk("guard_dp", 32'(dp), 32'h0);
      end else begin
        chk("slot_an", 32'(an), 32'(1 << s));
        if (bm[s] && ph == 1) begin
          chk("blink_seg", 32'(seg), 32'h0);
          chk("blink_dp", 32'(dp), 32'h0);
        end else begin
          chk("slot_seg", 32'(seg), 32'(exp_seg[s]));
          chk("slot_dp", 32'(dp), 32'(exp_dp[s]));
        end
      end
      chk("frame_tick", 32'(frame_tick), (j == 18) ? 32'h1 : 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    load       = 1'b1;
    digits_in  = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    blank_lz   = 1'b0;
    dp_mask    = '0;
    blink_mask = '0;
    bm         = '0;
    for (int i = 0; i < ND; i++) exp_dp[i] = 1'b0;

    // Reset, with load held high to confirm reset wins
    repeat (3) tick();
    chk("rst_seg", 32'(seg), 32'h0);
    chk("rst_dp", 32'(dp), 32'h0);
    chk("rst_an", 32'(an), 32'h0);
    chk("rst_ft", 32'(frame_tick), 32'h0);

    rst  = 1'b0;
    load = 1'b0;
    cyc  = 0;
    tick();
    chk("rel_guard_an", 32'(an), 32'h0);
    tick();
    chk("rel_an", 32'(an), 32'h01);
    chk("rst_over_load_seg", 32'(seg), 32'h3F);

    // Load 5,4,3,2,1 mid-slot 0
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("preload_seg", 32'(seg), 32'h3F);
    tick();
    chk("postload_seg", 32'(seg), 32'h6D);

    // Inputs change without load: display must not follow
    digits_in = {4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
    dp_mask   = '1;
    exp_seg[0] = 7'h6D; exp_seg[1] = 7'h66; exp_seg[2] = 7'h4F;
    exp_seg[3] = 7'h5B; exp_seg[4] = 7'h06;
    run_frame();
    run_frame();
    run_frame();

    // Load at the slot 3 -> slot 4 boundary
    wait_cyc(20, 15);
    chk("b4_boundary_an", 32'(an), 32'h08);
    chk("b4_boundary_seg", 32'(seg), 32'h5B);
    digits_in = {4'd8, 4'd2, 4'd3, 4'd4, 4'd5};
    dp_mask   = '0;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    chk("slot4_guard_an", 32'(an), 32'h0);
    tick();
    chk("slot4_an", 32'(an), 32'h10);
    chk("slot4_new_seg", 32'(seg), 32'h7F);
    exp_seg[4] = 7'h7F;
    run_frame();

    // Leading-zero blanking with a dp on a blanked digit
    blank_lz  = 1'b1;
    digits_in = {4'd0, 4'd0, 4'd0, 4'd7, 4'd0};
    dp_mask   = 5'b00100;
    load = 1'b1;
    tick();
    load = 1'b0;
    exp_seg[0] = 7'h3F; exp_seg[1] = 7'h07; exp_seg[2] = 7'h00;
    exp_seg[3] = 7'h00; exp_seg[4] = 7'h00;
    exp_dp[2]  = 1'b1;
    run_frame();

    // blank_lz is sampled live
    blank_lz = 1'b0;
    exp_seg[2] = 7'h3F; exp_seg[3] = 7'h3F; exp_seg[4] = 7'h3F;
    run_frame();

    // Blink on digit 2 = b
    digits_in  = {4'd3, 4'd4, 4'hB, 4'd2, 4'd1};
    dp_mask    = '0;
    blink_mask = 5'b00100;
    load = 1'b1;
    tick();
    load = 1'b0;
    bm = 5'b00100;
    exp_seg[0] = 7'h06; exp_seg[1] = 7'h5B; exp_seg[2] = 7'h7C;
    exp_seg[3] = 7'h66; exp_seg[4] = 7'h4F;
    for (int i = 0; i < ND; i++) exp_dp[i] = 1'b0;
    run_frame();
    run_frame();
    run_frame();
    run_frame();

    // Reset mid-slot 3 at prescaler 2
    wait_cyc(20, 14);
    rst = 1'b1;
    tick();
    chk("midrst_seg", 32'(seg), 32'h0);
    chk("midrst_dp", 32'(dp), 32'h0);
    chk("midrst_an", 32'(an), 32'h0);
    chk("midrst_ft", 32'(frame_tick), 32'h0);
    rst = 1'b0;
    cyc = 0;
    tick();
    chk("midrst_rel1_an", 32'(an), 32'h0);
    tick();
    chk("midrst_rel2_an", 32'(an), 32'h01);
    chk("midrst_rel2_seg", 32'(seg), 32'h3F);
    bm = '0;
    for (int i = 0; i < ND; i++) exp_seg[i] = 7'h3F;
    run_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
